// File: rtl/seq_unsigned_divider_4_if.sv
// Handshake and result bundle for the sequential unsigned divider.
// The requester drives the master side, and the divider sits on the slave side.
interface seq_unsigned_divider_4_if #(
    parameter int N = 4
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_unsigned_divider_4.sv
// Restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock, MSB first.
// The result registers change only on completion, so callers never see partial iterations.
module seq_unsigned_divider_4 #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_unsigned_divider_4_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   prem_q;
    logic [N-1:0]   dvs_q;
    logic [W-1:0]   dvd_q;
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;
    logic [W-1:0]   quo_q;
    logic [N-1:0]   rem_q;

    logic [N:0]     trial;
    logic           ge;
    logic [N-1:0]   prem_d;
    logic [W-1:0]   dvd_d;

    // The dividend register shifts left each step; its freed LSBs collect the quotient bits.
    always_comb begin
        trial  = {prem_q, dvd_q[W-1]};
        ge     = (trial >= {1'b0, dvs_q});
        prem_d = ge ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
        dvd_d  = {dvd_q[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dvd_q <= bus.dividend;
                        dvs_q <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= '0;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            prem_q  <= '0;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        quo_q   <= dvd_d;
                        rem_q   <= prem_d;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
